mdio_phy_ctrl: RTL and testbench

- Management controller for the external Ethernet PHY on the SGMII link.
- Sequences the PHY hardware reset (drives eth_reset_n), then runs IEEE 802.3 Clause 22 MDIO read/write frames on request over a valid/ready command interface.
- Sits beside the SGMII datapath in the top level. The MDIO tri-state buffer (IOBUF) is instantiated in the top level from mdio_o/mdio_oe/mdio_i.

---
 rtl/mdio_pkg.sv | 32 +++
 rtl/mdio_bit_timer.sv | 40 ++++
 rtl/mdio_phy_ctrl.sv | 149 ++++++++++++++
 tb/tb_mdio_phy_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// Shared types and Clause 22 frame constants for the PHY management controller.
package mdio_pkg;

    typedef enum logic [1:0] {
        RST_HOLD,
        RST_SETTLE,
        IDLE,
        FRAME
    } state_t;

    localparam logic [1:0] MDIO_ST            = 2'b01;
    localparam logic [1:0] MDIO_OP_WR         = 2'b01;
    localparam logic [1:0] MDIO_OP_RD         = 2'b10;
    localparam int         MDIO_PREAMBLE_BITS = 32;
    localparam int         MDIO_FRAME_BITS    = 65;
    localparam int         MDIO_TA_BIT        = 46;

    // Bits 0..63 of a frame, bit 0 in the MSB; read frames fill TA/data with ones (not driven).
    function automatic logic [63:0] mdio_frame(
        input logic        write,
        input logic [4:0]  phy_addr,
        input logic [4:0]  reg_addr,
        input logic [15:0] wdata
    );
        return {{MDIO_PREAMBLE_BITS{1'b1}}, MDIO_ST,
                write ? MDIO_OP_WR : MDIO_OP_RD,
                phy_addr, reg_addr,
                write ? 2'b10 : 2'b11,
                write ? wdata : 16'hFFFF};
    endfunction

endpackage

// File: rtl/mdio_bit_timer.sv
// MDC divider: each bit period is CLK_DIV cycles low then CLK_DIV cycles high.
module mdio_bit_timer #(
    parameter int CLK_DIV = 25
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic mdc,
    output logic sample,
    output logic bit_end
);
    localparam int DW = $clog2(2 * CLK_DIV);
    localparam logic [DW-1:0] HALF        = DW'(CLK_DIV);
    localparam logic [DW-1:0] SAMPLE_CNT  = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] LAST_CNT    = DW'(2 * CLK_DIV - 1);

    logic [DW-1:0] cnt;
    logic [DW-1:0] cnt_next;

    // NOTE: every variable assigned in always_comb gets a value on all paths, so no latch is inferred.
    always_comb begin
        cnt_next = (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            cnt <= '0;
            mdc <= 1'b0;
        end else begin
            cnt <= cnt_next;
            mdc <= (cnt_next >= HALF);
        end
    end

    // sample marks the last MDC-low cycle, bit_end the last cycle of the bit period
    assign sample  = enable && (cnt == SAMPLE_CNT);
    assign bit_end = enable && (cnt == LAST_CNT);

endmodule

// File: rtl/mdio_phy_ctrl.sv
// Ethernet PHY management: hardware reset sequencing followed by Clause 22 MDIO
// read/write frames issued over a valid/ready command interface.
module mdio_phy_ctrl
    import mdio_pkg::*;
#(
    parameter int CLK_DIV           = 25,
    parameter int RESET_CYCLES      = 2000000,
    parameter int POST_RESET_CYCLES = 1000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_phy_addr,
    input  logic [4:0]  cmd_reg_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_error,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i,
    output logic        phy_reset_n,
    output logic        phy_ready
);
    localparam int RSEQ_MAX = (RESET_CYCLES > POST_RESET_CYCLES) ? RESET_CYCLES : POST_RESET_CYCLES;
    localparam int RCW      = $clog2(RSEQ_MAX + 1);
    localparam logic [RCW-1:0] HOLD_LAST   = RCW'(RESET_CYCLES - 1);
    localparam logic [RCW-1:0] SETTLE_LAST = RCW'(POST_RESET_CYCLES - 1);
    localparam logic [6:0] TA_BIT        = 7'(MDIO_TA_BIT);
    localparam logic [6:0] TA_SAMPLE_BIT = 7'(MDIO_TA_BIT + 1);
    localparam logic [6:0] IDLE_BIT      = 7'(MDIO_FRAME_BITS - 1);

    state_t          state;
    logic [RCW-1:0]  rst_cnt;
    logic [6:0]      bit_cnt;
    logic [62:0]     shreg;
    logic            is_write;
    logic [15:0]     rd_shift;
    logic            ta_bit;

    logic            frame_en;
    logic            sample;
    logic            bit_end;
    logic [63:0]     frame_word;
    logic [6:0]      bit_next;
    logic            drive_next;

    assign frame_en = (state == FRAME);

    mdio_bit_timer #(.CLK_DIV(CLK_DIV)) u_bit_timer (
        .clock   (clock),
        .reset   (reset),
        .enable  (frame_en),
        .mdc     (mdc),
        .sample  (sample),
        .bit_end (bit_end)
    );

    // Reads release the bus from the TA bit onwards; nobody drives the idle bit.
    always_comb begin
        frame_word = mdio_frame(cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata);
        bit_next   = bit_cnt + 7'd1;
        drive_next = (bit_next < IDLE_BIT) && (is_write || (bit_next < TA_BIT));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= RST_HOLD;
            rst_cnt     <= '0;
            phy_reset_n <= 1'b0;
            phy_ready   <= 1'b0;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_error   <= 1'b0;
            mdio_o      <= 1'b1;
            mdio_oe     <= 1'b0;
            bit_cnt     <= '0;
            shreg       <= '0;
            is_write    <= 1'b0;
            rd_shift    <= '0;
            ta_bit      <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                RST_HOLD: begin
                    if (rst_cnt == HOLD_LAST) begin
                        phy_reset_n <= 1'b1;
                        rst_cnt     <= '0;
                        state       <= RST_SETTLE;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                RST_SETTLE: begin
                    if (rst_cnt == SETTLE_LAST) begin
                        phy_ready <= 1'b1;
                        cmd_ready <= 1'b1;
                        rst_cnt   <= '0;
                        state     <= IDLE;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        is_write  <= cmd_write;
                        shreg     <= frame_word[62:0];
                        mdio_o    <= frame_word[63];
                        mdio_oe   <= 1'b1;
                        bit_cnt   <= '0;
                        state     <= FRAME;
                    end
                end
                FRAME: begin
                    if (sample) begin
                        if (bit_cnt == TA_SAMPLE_BIT) begin
                            ta_bit <= mdio_i;
                        end else if (bit_cnt > TA_SAMPLE_BIT && bit_cnt < IDLE_BIT) begin
                            rd_shift <= {rd_shift[14:0], mdio_i};
                        end
                    end
                    if (bit_end) begin
                        if (bit_cnt == IDLE_BIT) begin
                            state     <= IDLE;
                            cmd_ready <= 1'b1;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= is_write ? 16'h0000 : rd_shift;
                            rsp_error <= is_write ? 1'b0 : ta_bit;
                            mdio_o    <= 1'b1;
                            mdio_oe   <= 1'b0;
                        end else begin
                            bit_cnt <= bit_next;
                            shreg   <= {shreg[61:0], 1'b0};
                            mdio_oe <= drive_next;
                            mdio_o  <= drive_next ? shreg[62] : 1'b1;
                        end
                    end
                end
                default: state <= RST_HOLD;
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_phy_ctrl.sv
// Directed bench for mdio_phy_ctrl: reset sequencing, write/read frames, PHY model, abort by reset.
module tb_mdio_phy_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [4:0]  cmd_phy_addr = '0;
    logic [4:0]  cmd_reg_addr = '0;
    logic [15:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_error;
    logic        mdc;
    logic        mdio_o;
    logic        mdio_oe;
    logic        mdio_i = 1'b1;
    logic        phy_reset_n;
    logic        phy_ready;

    int total = 0;
    int bad   = 0;

    // PHY model / bus monitor state (written only by the monitor process)
    logic        phy_en = 1'b0;
    logic [15:0] phy_data = '0;
    logic        prev_mdc = 1'b0;
    logic        prev_oe = 1'b0;
    int          rise_cnt = 0;
    logic [63:0] cap = '0;
    logic [64:0] oecap = '0;
    logic [15:0] pshift = '0;
    int          acc_cnt = 0;
    int          rsp_cnt = 0;
    logic [63:0] cap_q[$];
    logic [64:0] oe_q[$];

    mdio_phy_ctrl #(
        .CLK_DIV           (2),
        .RESET_CYCLES      (10),
        .POST_RESET_CYCLES (5)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_phy_addr (cmd_phy_addr),
        .cmd_reg_addr (cmd_reg_addr),
        .cmd_wdata    (cmd_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_error    (rsp_error),
        .mdc          (mdc),
        .mdio_o       (mdio_o),
        .mdio_oe      (mdio_oe),
        .mdio_i       (mdio_i),
        .phy_reset_n  (phy_reset_n),
        .phy_ready    (phy_ready)
    );

    always #5 clock = ~clock;

    // Captures bits on MDC rising edges and answers reads like a PHY (drives after MDC rises).
    always @(negedge clock) begin
        if (mdio_oe && !prev_oe) begin
            rise_cnt = 0;
            cap      = '0;
            oecap    = '0;
            pshift   = phy_data;
        end
        if (mdc && !prev_mdc) begin
            if (rise_cnt < 64) cap = {cap[62:0], mdio_o};
            oecap = {oecap[63:0], mdio_oe};
            if (rise_cnt == 63) cap_q.push_back(cap);
            if (rise_cnt == 64) oe_q.push_back(oecap);
            if (!phy_en) begin
                mdio_i = 1'b1;
            end else if (rise_cnt + 1 == 47) begin
                mdio_i = 1'b0;
            end else if (rise_cnt + 1 >= 48 && rise_cnt + 1 <= 63) begin
                mdio_i = pshift[15];
                pshift = {pshift[14:0], 1'b0};
            end else begin
                mdio_i = 1'b1;
            end
            rise_cnt = rise_cnt + 1;
        end
        if (cmd_valid && cmd_ready) acc_cnt = acc_cnt + 1;
        if (rsp_valid) rsp_cnt = rsp_cnt + 1;
        prev_mdc = mdc;
        prev_oe  = mdio_oe;
    end

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Sample point: just after the falling edge, after the monitor has run.
    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic run_reset_seq(input string tag);
        int  first_rn;
        int  first_rdy;
        int  first_crdy;
        logic any_mdc;
        logic any_oe;
        first_rn = -1; first_rdy = -1; first_crdy = -1;
        any_mdc = 1'b0; any_oe = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        for (int k = 0; k <= 15; k++) begin
            tick();
            if (phy_reset_n && first_rn < 0) first_rn = k;
            if (phy_ready && first_rdy < 0) first_rdy = k;
            if (cmd_ready && first_crdy < 0) first_crdy = k;
            any_mdc = any_mdc | mdc;
            any_oe  = any_oe | mdio_oe;
        end
        check({tag, "_phy_reset_n_rise"}, 65'(first_rn), 65'(10));
        check({tag, "_phy_ready_rise"}, 65'(first_rdy), 65'(15));
        check({tag, "_cmd_ready_rise"}, 65'(first_crdy), 65'(15));
        check({tag, "_mdc_quiet"}, 65'(any_mdc), 65'(0));
        check({tag, "_oe_quiet"}, 65'(any_oe), 65'(0));
    endtask

    task automatic start_cmd(input logic w, input logic [4:0] pa, input logic [4:0] ra,
                             input logic [15:0] wd, output logic ok);
        @(posedge clock); #1;
        cmd_write = w; cmd_phy_addr = pa; cmd_reg_addr = ra; cmd_wdata = wd;
        cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 65'(0), 65'(1));
        @(posedge clock); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int off, output int lat);
        lat = -1;
        for (int i = 1; i <= 2000; i++) begin
            tick();
            if (rsp_valid) begin
                lat = i + off;
                break;
            end
        end
        if (lat < 0) check("rsp_timeout", 65'(0), 65'(1));
    endtask

    task automatic pop_frame(output logic [63:0] c, output logic [64:0] oe);
        if (cap_q.size() == 0 || oe_q.size() == 0) begin
            check("frame_capture_missing", 65'(0), 65'(1));
            c = '0; oe = '0;
        end else begin
            c  = cap_q.pop_front();
            oe = oe_q.pop_front();
        end
    endtask

    initial begin
        logic        ok;
        int          lat;
        logic [63:0] c;
        logic [64:0] oe;
        logic [64:0] oe_wr;
        logic [64:0] oe_rd;
        int          base_acc;
        int          base_rsp;
        oe_wr = {{64{1'b1}}, 1'b0};
        oe_rd = {{46{1'b1}}, {19{1'b0}}};

        // Reset values, then the reset sequence timing
        repeat (3) @(posedge clock);
        tick();
        check("reset_values",
              65'({phy_reset_n, phy_ready, cmd_ready, rsp_valid, rsp_error, mdc, mdio_o, mdio_oe, rsp_rdata}),
              65'({8'b0000_0010, 16'h0000}));
        run_reset_seq("seq1");

        // Write PHY 1 reg 0 = 0x1140: ST=01 OP=01 00001 00000 TA=10 -> 0x5082
        start_cmd(1'b1, 5'h01, 5'h00, 16'h1140, ok);
        wait_rsp(0, lat);
        pop_frame(c, oe);
        check("wr_bits", 65'(c), 65'(64'hFFFF_FFFF_5082_1140));
        check("wr_oe", oe, oe_wr);
        check("wr_latency", 65'(lat), 65'(261));
        check("wr_rdata_err", 65'({rsp_rdata, rsp_error}), 65'(0));

        // Read PHY 3 reg 2 with a responding PHY
        phy_en = 1'b1;
        phy_data = 16'h0141;
        start_cmd(1'b0, 5'h03, 5'h02, 16'h0000, ok);
        wait_rsp(0, lat);
        pop_frame(c, oe);
        check("rd_header_bits", 65'(c[63:18]), 65'({32'hFFFF_FFFF, 2'b01, 2'b10, 5'h03, 5'h02}));
        check("rd_oe", oe, oe_rd);
        check("rd_latency", 65'(lat), 65'(261));
        check("rd_rdata", 65'(rsp_rdata), 65'(16'h0141));
        check("rd_error", 65'(rsp_error), 65'(0));
        check("rd_rsp_hold", 65'(rsp_cnt), 65'(2));

        // Read with nobody answering: the pull-up leaves all ones
        phy_en = 1'b0;
        start_cmd(1'b0, 5'h07, 5'h11, 16'h0000, ok);
        wait_rsp(0, lat);
        pop_frame(c, oe);
        check("nophy_error", 65'(rsp_error), 65'(1));
        check("nophy_rdata", 65'(rsp_rdata), 65'(16'hFFFF));

        // Abort a write around bit 20 with reset
        start_cmd(1'b1, 5'h04, 5'h05, 16'hBEEF, ok);
        for (int i = 0; i < 400; i++) begin
            tick();
            if (rise_cnt >= 21) break;
        end
        base_rsp = rsp_cnt;
        base_acc = acc_cnt;
        @(posedge clock); #1;
        reset = 1'b1;
        tick();
        check("abort_mid_frame_oe", 65'({mdio_oe, phy_ready}), 65'(2'b11));
        tick();
        check("abort_outputs", 65'({mdio_oe, mdc, phy_reset_n, phy_ready, cmd_ready}), 65'(0));

        // Command A held from reset through phy_ready; B presented while A runs
        cmd_write = 1'b1; cmd_phy_addr = 5'h02; cmd_reg_addr = 5'h03; cmd_wdata = 16'hA5A5;
        cmd_valid = 1'b1;
        repeat (2) @(posedge clock);
        run_reset_seq("seq2");
        check("abort_no_rsp", 65'(rsp_cnt), 65'(base_rsp));
        check("held_cmd_accepted", 65'(acc_cnt), 65'(base_acc + 1));
        @(posedge clock); #1;
        cmd_phy_addr = 5'h1F; cmd_reg_addr = 5'h1F; cmd_wdata = 16'h5A5A;
        wait_rsp(0, lat);
        check("a_latency", 65'(lat), 65'(261));
        check("a_ready_rdata_err", 65'({cmd_ready, rsp_rdata, rsp_error}), 65'({1'b1, 16'h0000, 1'b0}));
        check("one_accept_per_frame", 65'(acc_cnt), 65'(base_acc + 2));
        pop_frame(c, oe);
        check("a_bits", 65'(c), 65'(64'hFFFF_FFFF_510E_A5A5));
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        tick();
        check("b_bit0_after_rsp", 65'({mdio_oe, mdc, cmd_ready}), 65'(3'b100));
        wait_rsp(1, lat);
        check("b_latency", 65'(lat), 65'(261));
        pop_frame(c, oe);
        check("b_bits", 65'(c), 65'(64'hFFFF_FFFF_5FFE_5A5A));
        check("b_oe", oe, oe_wr);
        check("final_accepts", 65'(acc_cnt), 65'(base_acc + 2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
